// File: rtl/sink_x_if.sv
// X-channel receive interface for sink_x.
// Carries three groups of signals:
//   - X handshake into the sink: io_x_valid, io_x_ready, io_x_bits_address.
//   - Request to the cache scheduler: io_req_valid, io_req_ready, io_req_tag, io_req_set.
//   - Completion and status: io_done, io_busy, plus io_err when SINK_X_ERR_EN is defined.
// Modports:
//   - slave: the sink side.
//   - master: the environment side (SourceX and the scheduler).
interface sink_x_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned SET_W    = 10
);
  localparam int unsigned TAG_W = ADDR_W - SET_W - OFFSET_W;

  logic              io_x_valid;
  logic              io_x_ready;
  logic [ADDR_W-1:0] io_x_bits_address;
  logic              io_req_valid;
  logic              io_req_ready;
  logic [TAG_W-1:0]  io_req_tag;
  logic [SET_W-1:0]  io_req_set;
  logic              io_done;
  logic              io_busy;
`ifdef SINK_X_ERR_EN
  logic              io_err;
`endif

  modport slave (
    input  io_x_valid, io_x_bits_address, io_req_ready, io_done,
    output io_x_ready, io_req_valid, io_req_tag, io_req_set, io_busy
`ifdef SINK_X_ERR_EN
    , output io_err
`endif
  );

  modport master (
    output io_x_valid, io_x_bits_address, io_req_ready, io_done,
    input  io_x_ready, io_req_valid, io_req_tag, io_req_set, io_busy
`ifdef SINK_X_ERR_EN
    , input io_err
`endif
  );
endinterface

// File: rtl/sink_x.sv
// sink_x: the receiving end of the X (flush/control) channel.
// Flush addresses are buffered in a DEPTH-entry FIFO. The sink issues one tag/set request
// at a time to the scheduler and then waits for the scheduler's io_done pulse.
// Ports:
//   - clock: rising-edge clock.
//   - reset: synchronous, active-high.
//   - bus (sink_x_if.slave): X handshake, scheduler request, done/busy and optional err.
// Optional feature, selected by the macro SINK_X_ERR_EN:
//   - an address with non-zero offset bits is dropped;
//   - io_err pulses in the cycle after that address was accepted.
module sink_x #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned SET_W    = 10,
  parameter int unsigned DEPTH    = 2
) (
  input logic    clock,
  input logic    reset,
  sink_x_if.slave bus
);
  localparam int unsigned TAG_W   = ADDR_W - SET_W - OFFSET_W;
  localparam int unsigned ENTRY_W = TAG_W + SET_W;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  // Only tag and set are stored; the offset bits are never issued.
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] head;

  logic x_ready;
  logic x_fire;
  logic enq;
  logic req_valid;
  logic req_fire;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Readiness looks only at the registered count, so a pop does not free a slot
  // until the following cycle.
  assign x_ready   = !reset && (count_q < CNT_W'(DEPTH));
  assign x_fire    = bus.io_x_valid && x_ready;
  assign req_valid = !reset && (state_q == StIdle) && (count_q != '0);
  assign req_fire  = req_valid && bus.io_req_ready;

`ifdef SINK_X_ERR_EN
  logic offset_bad;
  logic err_q;

  assign offset_bad = (bus.io_x_bits_address[OFFSET_W-1:0] != '0);
  assign enq        = x_fire && !offset_bad;
  assign bus.io_err = !reset && err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= x_fire && offset_bad;
    end
  end
`else
  // The offset bits are ignored in this build.
  logic unused_offset;
  assign unused_offset = ^bus.io_x_bits_address[OFFSET_W-1:0];
  assign enq           = x_fire;
`endif

  // Queue pointers, occupancy and the issue FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (enq) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (req_fire) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (enq && !req_fire) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!enq && req_fire) begin
        count_q <= count_q - CNT_W'(1);
      end
      unique case (state_q)
        StIdle: if (req_fire) state_q <= StWait;
        // io_done is ignored in StIdle, so a late pulse has no effect.
        StWait: if (bus.io_done) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // No reset is needed: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= bus.io_x_bits_address[ADDR_W-1:OFFSET_W];
    end
  end

  // The head entry can only change on a pop, so tag and set stay stable while a
  // request waits for io_req_ready.
  assign head             = mem_q[rd_ptr_q];
  assign bus.io_x_ready   = x_ready;
  assign bus.io_req_valid = req_valid;
  assign bus.io_req_tag   = head[ENTRY_W-1:SET_W];
  assign bus.io_req_set   = head[SET_W-1:0];
  assign bus.io_busy      = !reset && ((count_q != '0) || (state_q == StWait));
endmodule

// File: tb/tb_sink_x.sv
// Self-checking bench for sink_x.
// The reference model is an address queue plus a request-outstanding flag.
// It runs directed scenarios followed by randomized traffic.
module tb_sink_x;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned SET_W    = 10;
  localparam int unsigned DEPTH    = 2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  // Reference model state.
  logic [31:0] model_q[$];
  logic        waiting;
  logic        err_pend;

  sink_x_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .SET_W(SET_W)) bus ();

  sink_x #(
    .ADDR_W  (ADDR_W),
    .OFFSET_W(OFFSET_W),
    .SET_W   (SET_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the outputs against the model, then advance
  // the model and the clock.
  task automatic cycle(input logic v, input logic [31:0] a, input logic rr, input logic dn);
    logic exp_ready;
    logic exp_valid;
    logic exp_busy;
    logic fire_x;
    logic fire_req;
    bus.io_x_valid        = v;
    bus.io_x_bits_address = a;
    bus.io_req_ready      = rr;
    bus.io_done           = dn;
    #1;
    exp_ready = (model_q.size() < DEPTH);
    exp_valid = !waiting && (model_q.size() != 0);
    exp_busy  = (model_q.size() != 0) || waiting;
    check("x_ready", 32'(bus.io_x_ready), 32'(exp_ready));
    check("req_valid", 32'(bus.io_req_valid), 32'(exp_valid));
    check("busy", 32'(bus.io_busy), 32'(exp_busy));
    if (exp_valid) begin
      check("req_tag", 32'(bus.io_req_tag), 32'(16'(model_q[0] >> 16)));
      check("req_set", 32'(bus.io_req_set), 32'(10'((model_q[0] >> 6) & 32'h3ff)));
    end
    fire_x   = v && exp_ready;
    fire_req = exp_valid && rr;
`ifdef SINK_X_ERR_EN
    check("err", 32'(bus.io_err), 32'(err_pend));
    err_pend = fire_x && ((a % 64) != 0);
    if (fire_x && ((a % 64) != 0)) fire_x = 1'b0;
`endif
    if (waiting && dn) waiting = 1'b0;
    if (fire_req) begin
      void'(model_q.pop_front());
      waiting = 1'b1;
    end
    if (fire_x) model_q.push_back(a);
    @(posedge clock);
    #1;
    bus.io_x_valid = 1'b0;
    bus.io_done    = 1'b0;
  endtask

  // Hold reset for n cycles with io_x_valid high; the outputs must stay quiet throughout.
  task automatic do_reset(input int n, input logic dn);
    reset          = 1'b1;
    bus.io_x_valid = 1'b1;
    bus.io_done    = dn;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_x_ready", 32'(bus.io_x_ready), 32'h0);
      check("rst_req_valid", 32'(bus.io_req_valid), 32'h0);
      check("rst_busy", 32'(bus.io_busy), 32'h0);
`ifdef SINK_X_ERR_EN
      check("rst_err", 32'(bus.io_err), 32'h0);
`endif
      @(posedge clock);
      #1;
    end
    reset          = 1'b0;
    bus.io_x_valid = 1'b0;
    bus.io_done    = 1'b0;
    model_q.delete();
    waiting  = 1'b0;
    err_pend = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        v;
    logic        rr;
    logic        dn;
    checks                = 0;
    errors                = 0;
    waiting               = 1'b0;
    err_pend              = 1'b0;
    reset                 = 1'b1;
    bus.io_x_valid        = 1'b1;
    bus.io_x_bits_address = 32'hdead_bec0;
    bus.io_req_ready      = 1'b1;
    bus.io_done           = 1'b0;

    do_reset(3, 1'b0);

    // A single flush: issued in the next cycle, then held off until io_done.
    cycle(1'b1, 32'h1234_5640, 1'b1, 1'b0);
    check("tag_lit", 32'(bus.io_req_tag), 32'h1234);
    check("set_lit", 32'(bus.io_req_set), 32'h159);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill the FIFO; C is refused until a slot frees, and A, B, C come out in order.
    cycle(1'b1, 32'haaaa_0040, 1'b0, 1'b0);
    cycle(1'b1, 32'hbbbb_0080, 1'b0, 1'b0);
    cycle(1'b1, 32'hcccc_00c0, 1'b0, 1'b0);
    cycle(1'b1, 32'hcccc_00c0, 1'b1, 1'b0);
    cycle(1'b1, 32'hcccc_00c0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Full FIFO with a push and a pop in the same cycle; the pointers wrap.
    cycle(1'b1, 32'h1111_1000, 1'b0, 1'b0);
    cycle(1'b1, 32'h2222_2000, 1'b0, 1'b0);
    cycle(1'b1, 32'h3333_3000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h4444_4000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);

    // io_done while idle with an empty FIFO changes nothing.
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset while in WAIT; a late io_done is ignored afterwards.
    cycle(1'b1, 32'h5555_5000, 1'b1, 1'b0);
    cycle(1'b1, 32'h6666_6000, 1'b1, 1'b0);
    do_reset(1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h7777_7000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef SINK_X_ERR_EN
    // A misaligned address is dropped and flagged; an aligned one is issued normally.
    cycle(1'b1, 32'h0000_0044, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0040, 1'b0, 1'b0);
    check("set_err_lit", 32'(bus.io_req_set), 32'h001);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 2) != 0);
      dn = ($urandom_range(0, 3) == 0);
      a  = $urandom;
`ifdef SINK_X_ERR_EN
      if ($urandom_range(0, 3) != 0) a[5:0] = 6'h0;
`else
      if ($urandom_range(0, 1) != 0) a[5:0] = 6'h0;
`endif
      cycle(v, a, rr, dn);
      if (i == 200) do_reset(2, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
